micro_alpha_veryl_mux_arbiter: RTL and testbench

MICRO_ALPHA_VERYL_MUX_ARBITER -- requirements
Module: micro_alpha_veryl_mux_arbiter

---
 rtl/micro_alpha_veryl_mux_arbiter.sv | 83 ++++++++
 tb/tb_micro_alpha_veryl_mux_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/micro_alpha_veryl_mux_arbiter.sv
// rtl/micro_alpha_veryl_mux_arbiter.sv - two-requester round-robin arbiter feeding a one-word output register
// The operand mux is a separate module so the select path stays visible on its own.

module micro_alpha_veryl_mux (
    input  logic [31:0] din [0:1],
    input  logic        selector,
    output logic [31:0] dout
);

    assign dout = din[selector];

endmodule

module micro_alpha_veryl_mux_arbiter #(
    parameter logic RESET_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data [0:1],
    output logic [1:0]  req_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_src,
    input  logic        out_ready
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic        state;
    logic        prio;
    logic        grant;
    logic        accept;
    logic        req_xfer;
    logic [31:0] mux_dout;

    assign out_valid = (state == FULL);
    assign accept    = !out_valid || out_ready;

    // A lone requester wins outright; otherwise (both or none) prio decides.
    always_comb begin
        grant = prio;
        if (req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (!rst && accept && req_valid[grant]) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign req_xfer = |(req_valid & req_ready);

    micro_alpha_veryl_mux u_mux (
        .din      (req_data),
        .selector (grant),
        .dout     (mux_dout)
    );

    // prio only moves on an accepted request, so a withdrawn request never steals a turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= 32'h0;
            out_src  <= 1'b0;
            prio     <= RESET_PRIO;
        end else if (req_xfer) begin
            state    <= FULL;
            out_data <= mux_dout;
            out_src  <= grant;
            prio     <= ~grant;
        end else if (out_valid && out_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_micro_alpha_veryl_mux_arbiter.sv
// tb/tb_micro_alpha_veryl_mux_arbiter.sv - self-checking bench for micro_alpha_veryl_mux_arbiter

module tb_micro_alpha_veryl_mux_arbiter;

    localparam logic RP = 1'b0;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_data [0:1];
    logic [1:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_ready;

    micro_alpha_veryl_mux_arbiter #(.RESET_PRIO(RP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one holding slot, a priority bit and an in-order word queue.
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    logic        m_src   = 1'b0;
    logic        m_prio  = RP;
    logic [31:0] sb [$];
    int          grants [0:1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        g;
        logic        acc;
        logic [1:0]  er;
        logic [31:0] wd;
        @(negedge clk);
        acc = !m_valid || out_ready;
        if (req_valid == 2'b01)      g = 1'b0;
        else if (req_valid == 2'b10) g = 1'b1;
        else                         g = m_prio;
        er = (!rst && acc && req_valid[g]) ? (2'b01 << g) : 2'b00;
        wd = req_data[g];
        chk("req_ready", {30'h0, req_ready}, {30'h0, er});
        if (!rst && out_valid && out_ready) begin
            if (sb.size() > 0) chk("sb_order", out_data, sb.pop_front());
            else               chk("sb_spurious_out", {31'h0, out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_data = 32'h0; m_src = 1'b0; m_prio = RP;
            sb.delete();
        end else if (er != 2'b00) begin
            m_valid = 1'b1; m_data = wd; m_src = g; m_prio = ~g;
            sb.push_back(wd);
            grants[g]++;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        chk("out_data",  out_data, m_data);
        chk("out_src",   {31'h0, out_src}, {31'h0, m_src});
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; out_ready = 1'b1;
        req_data[0] = 32'hA5A5; req_data[1] = 32'h5A5A;
        grants[0] = 0; grants[1] = 0;

        step();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);

        // single requester
        rst = 1'b0; req_valid = 2'b01;
        step();
        chk("single_src", {31'h0, out_src}, 32'h0);
        chk("single_data", out_data, 32'hA5A5);

        // contention from reset priority
        rst = 1'b1; req_valid = 2'b00;
        step();
        rst = 1'b0; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cont_src", {31'h0, out_src}, (i % 2 == 0) ? {31'h0, RP} : {31'h0, ~RP});
            chk("cont_data", out_data, (i % 2 == 0) ? req_data[RP] : req_data[~RP]);
        end

        // backpressure while full of the last word
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", out_data, req_data[~RP]);
        end
        out_ready = 1'b1;
        step();
        chk("bp_refill", out_data, req_data[RP]);

        // drain, then confirm prio survived the idle cycle
        req_valid = 2'b00;
        step();
        chk("drain_valid", {31'h0, out_valid}, 32'h0);
        req_valid = 2'b11;
        step();
        chk("drain_prio", {31'h0, out_src}, {31'h0, ~RP});

        // reset while full with both requesters valid
        rst = 1'b1;
        step();
        chk("midrst_data", out_data, 32'h0);
        rst = 1'b0;
        step();
        chk("midrst_grant", {31'h0, out_src}, {31'h0, RP});

        // fairness under continuous contention with random backpressure
        grants[0] = 0; grants[1] = 0;
        req_valid = 2'b11;
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            req_data[0] = $urandom; req_data[1] = $urandom;
            step();
        end
        chk("fair_diff", 32'((grants[0] > grants[1]) ? grants[0] - grants[1] : grants[1] - grants[0]) <= 1 ? 32'h1 : 32'h0, 32'h1);

        // random soak
        for (int i = 0; i < 1000; i++) begin
            rst = 1'($urandom_range(0, 99) == 0);
            req_valid = 2'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            req_data[0] = $urandom; req_data[1] = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
